// File: rtl/cs_mem_arbiter_pkg.sv
// Shared types and helpers for the round-robin memory-port arbiter.
// Holds the FSM state encoding, default bus widths and the response-error encoder.
package cs_mem_arb_pkg;

   localparam int ADDR_W_DEF = 15;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_RANGE,
      ERR_MEM,
      ERR_TIMEOUT
   } err_kind_t;

   typedef struct packed {
      logic error;
      logic timeout;
   } rsp_err_t;

   // Any failure raises error; only a stalled memory also raises timeout.
   function automatic rsp_err_t encodeRspError(input err_kind_t kind);
      rsp_err_t r;
      r.error   = (kind != ERR_NONE);
      r.timeout = (kind == ERR_TIMEOUT);
      return r;
   endfunction

endpackage

// File: rtl/cs_mem_arbiter_if.sv
// Requester-side and memory-side handshake bundle for cs_mem_arbiter.
// The master modport is the arbiter's view; slave is the requesters-plus-memory view.
interface cs_mem_arbiter_if
   import cs_mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) ();

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_wr_rd;

   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_error;
   logic                      rsp_timeout;

   logic                      mem_valid;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic                      mem_wr_rd;
   logic                      mem_ready;
   logic [DATA_W-1:0]         mem_rdata;
   logic                      mem_error;

   logic                      busy;

   modport master (
      input  req_valid, req_addr, req_wdata, req_wr_rd,
      input  mem_ready, mem_rdata, mem_error,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      output mem_valid, mem_addr, mem_wdata, mem_wr_rd,
      output busy
   );

   modport slave (
      output req_valid, req_addr, req_wdata, req_wr_rd,
      output mem_ready, mem_rdata, mem_error,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      input  mem_valid, mem_addr, mem_wdata, mem_wr_rd,
      input  busy
   );

endinterface

// File: rtl/cs_mem_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping modulo NUM_REQ.
module cs_rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grantIdx,
   output logic               o_valid
);

   // Scan candidates in priority order starting from the pointer; the first hit wins.
   always_comb begin
      o_grant    = '0;
      o_grantIdx = '0;
      o_valid    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!o_valid && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
            o_valid                                = 1'b1;
            o_grant[(int'(i_ptr) + k) % NUM_REQ]   = 1'b1;
            o_grantIdx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/cs_mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one memory port between NUM_REQ requesters,
// with local address range check, memory timeout and a one-cycle response pulse.
module cs_mem_arbiter
   import cs_mem_arb_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_ADDR = 4095,
   parameter int TIMEOUT  = 64
) (
   input logic                 clk,
   input logic                 rst,
   cs_mem_arbiter_if.master    bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MAX_ADDR);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

   state_t               r_state;
   logic [IDX_W-1:0]     r_ptr;
   logic [NUM_REQ-1:0]   r_grantOh;
   logic [CNT_W-1:0]     r_cnt;

   logic                 r_memValid;
   logic [ADDR_W-1:0]    r_memAddr;
   logic [DATA_W-1:0]    r_memWdata;
   logic                 r_memWrRd;

   logic [NUM_REQ-1:0]   r_rspValid;
   logic [DATA_W-1:0]    r_rspRdata;
   logic                 r_rspError;
   logic                 r_rspTimeout;

   logic [NUM_REQ-1:0]   w_grant;
   logic [IDX_W-1:0]     w_grantIdx;
   logic                 w_grantValid;
   logic [ADDR_W-1:0]    w_selAddr;
   logic [DATA_W-1:0]    w_selWdata;
   logic                 w_selWrRd;
   logic                 w_addrBad;
   logic [IDX_W-1:0]     w_nextPtr;
   rsp_err_t             w_rangeErr;
   rsp_err_t             w_timeoutErr;
   rsp_err_t             w_busyErr;

   cs_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .i_req      (bus.req_valid),
      .i_ptr      (r_ptr),
      .o_grant    (w_grant),
      .o_grantIdx (w_grantIdx),
      .o_valid    (w_grantValid)
   );

   assign w_selAddr    = bus.req_addr[w_grantIdx*ADDR_W +: ADDR_W];
   assign w_selWdata   = bus.req_wdata[w_grantIdx*DATA_W +: DATA_W];
   assign w_selWrRd    = bus.req_wr_rd[w_grantIdx];
   assign w_addrBad    = (w_selAddr > ADDR_MAX);
   assign w_nextPtr    = (w_grantIdx == IDX_LAST) ? '0 : w_grantIdx + 1'b1;
   assign w_rangeErr   = encodeRspError(ERR_RANGE);
   assign w_timeoutErr = encodeRspError(ERR_TIMEOUT);
   assign w_busyErr    = encodeRspError(bus.mem_error ? ERR_MEM : ERR_NONE);

   // Accept is only offered while idle, so a grant can never overlap a transaction.
   assign bus.req_ready   = (r_state == IDLE) ? w_grant : '0;
   assign bus.busy        = (r_state != IDLE);
   assign bus.mem_valid   = r_memValid;
   assign bus.mem_addr    = r_memAddr;
   assign bus.mem_wdata   = r_memWdata;
   assign bus.mem_wr_rd   = r_memWrRd;
   assign bus.rsp_valid   = r_rspValid;
   assign bus.rsp_rdata   = r_rspRdata;
   assign bus.rsp_error   = r_rspError;
   assign bus.rsp_timeout = r_rspTimeout;

   // Transaction sequencer: response fields only change when entering RESP, so they
   // hold the last result between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ptr        <= '0;
         r_grantOh    <= '0;
         r_cnt        <= '0;
         r_memValid   <= 1'b0;
         r_memAddr    <= '0;
         r_memWdata   <= '0;
         r_memWrRd    <= 1'b0;
         r_rspValid   <= '0;
         r_rspRdata   <= '0;
         r_rspError   <= 1'b0;
         r_rspTimeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grantValid) begin
                  r_grantOh <= w_grant;
                  r_ptr     <= w_nextPtr;
                  if (w_addrBad) begin
                     r_state      <= RESP;
                     r_rspValid   <= w_grant;
                     r_rspRdata   <= '0;
                     r_rspError   <= w_rangeErr.error;
                     r_rspTimeout <= w_rangeErr.timeout;
                  end else begin
                     r_state    <= BUSY;
                     r_memValid <= 1'b1;
                     r_memAddr  <= w_selAddr;
                     r_memWdata <= w_selWdata;
                     r_memWrRd  <= w_selWrRd;
                     r_cnt      <= '0;
                  end
               end
            end
            // Ready is checked before the count limit so a last-cycle completion succeeds.
            BUSY: begin
               if (bus.mem_ready) begin
                  r_state      <= RESP;
                  r_memValid   <= 1'b0;
                  r_rspValid   <= r_grantOh;
                  r_rspRdata   <= r_memWrRd ? '0 : bus.mem_rdata;
                  r_rspError   <= w_busyErr.error;
                  r_rspTimeout <= w_busyErr.timeout;
               end else if (r_cnt == CNT_LAST) begin
                  r_state      <= RESP;
                  r_memValid   <= 1'b0;
                  r_rspValid   <= r_grantOh;
                  r_rspRdata   <= '0;
                  r_rspError   <= w_timeoutErr.error;
                  r_rspTimeout <= w_timeoutErr.timeout;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               r_state    <= IDLE;
               r_rspValid <= '0;
            end
            default: begin
               r_state    <= IDLE;
               r_memValid <= 1'b0;
               r_rspValid <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cs_mem_arbiter.sv
// Directed self-checking bench for cs_mem_arbiter with NUM_REQ=2, TIMEOUT=64.
// Inputs change and outputs are sampled shortly after the falling edge.
module tb_cs_mem_arbiter;
   import cs_mem_arb_pkg::*;

   localparam int NR = 2;
   localparam int AW = 15;
   localparam int DW = 32;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   cs_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   cs_mem_arbiter #(
      .NUM_REQ  (NR),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_ADDR (4095),
      .TIMEOUT  (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [14:0] a0, input logic [14:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] wr);
      bus.req_valid = valid;
      bus.req_addr  = {a1, a0};
      bus.req_wdata = {d1, d0};
      bus.req_wr_rd = wr;
   endtask

   // Directed sequence; pointer state carries from one scenario into the next.
   initial begin
      logic [1:0]  expOh;
      logic [14:0] expAddr;
      int          hi;

      rst = 1'b1;
      applyStimulus(2'b00, 15'h0, 15'h0, 32'h0, 32'h0, 2'b00);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_error = 1'b0;
      step();
      step();
      checkOutput("rst_busy",      bus.busy,        1'b0);
      checkOutput("rst_mem_valid", bus.mem_valid,   1'b0);
      checkOutput("rst_rsp_valid", bus.rsp_valid,   2'b00);
      checkOutput("rst_req_ready", bus.req_ready,   2'b00);
      checkOutput("rst_rsp_error", bus.rsp_error,   1'b0);
      rst = 1'b0;
      step();

      $display("[TB] single read");
      applyStimulus(2'b01, 15'h010, 15'h0, 32'h0, 32'h0, 2'b00);
      #1;
      checkOutput("t1_ready", bus.req_ready, 2'b01);
      step();
      applyStimulus(2'b00, 15'h0, 15'h0, 32'h0, 32'h0, 2'b00);
      checkOutput("t1_mem_valid", bus.mem_valid, 1'b1);
      checkOutput("t1_mem_addr",  bus.mem_addr,  15'h010);
      checkOutput("t1_mem_wr_rd", bus.mem_wr_rd, 1'b0);
      checkOutput("t1_busy",      bus.busy,      1'b1);
      step();
      checkOutput("t1_mem_valid_hold", bus.mem_valid, 1'b1);
      step();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      #1;
      checkOutput("t1_no_early_rsp", bus.rsp_valid, 2'b00);
      step();
      bus.mem_ready = 1'b0;
      checkOutput("t1_rsp_valid",  bus.rsp_valid, 2'b01);
      checkOutput("t1_rsp_rdata",  bus.rsp_rdata, 32'hDEADBEEF);
      checkOutput("t1_rsp_error",  bus.rsp_error, 1'b0);
      checkOutput("t1_mem_dropped", bus.mem_valid, 1'b0);
      step();
      checkOutput("t1_rsp_pulse_end", bus.rsp_valid, 2'b00);
      checkOutput("t1_rdata_hold",    bus.rsp_rdata, 32'hDEADBEEF);
      checkOutput("t1_idle",          bus.busy,      1'b0);

      $display("[TB] contention, pointer now at requester 1");
      bus.mem_ready = 1'b1;
      applyStimulus(2'b11, 15'h100, 15'h200, 32'h0, 32'h0, 2'b00);
      for (int t = 0; t < 8; t++) begin
         expOh   = (t % 2 == 0) ? 2'b10 : 2'b01;
         expAddr = (t % 2 == 0) ? 15'h200 : 15'h100;
         bus.mem_rdata = 32'h12340000 + 32'(t);
         #1;
         checkOutput("t2_grant", bus.req_ready, expOh);
         step();
         checkOutput("t2_mem_addr",       bus.mem_addr,  expAddr);
         checkOutput("t2_no_grant_busy",  bus.req_ready, 2'b00);
         step();
         checkOutput("t2_rsp_valid",      bus.rsp_valid, expOh);
         checkOutput("t2_rsp_rdata",      bus.rsp_rdata, 32'h12340000 + 32'(t));
         checkOutput("t2_no_grant_resp",  bus.req_ready, 2'b00);
         step();
         checkOutput("t2_single_pulse",   bus.rsp_valid, 2'b00);
      end
      bus.mem_ready = 1'b0;
      applyStimulus(2'b00, 15'h0, 15'h0, 32'h0, 32'h0, 2'b00);

      $display("[TB] out-of-range write");
      applyStimulus(2'b10, 15'h0, 15'h1000, 32'h0, 32'h55AA55AA, 2'b10);
      #1;
      checkOutput("t3_ready", bus.req_ready, 2'b10);
      step();
      applyStimulus(2'b00, 15'h0, 15'h0, 32'h0, 32'h0, 2'b00);
      checkOutput("t3_mem_valid",   bus.mem_valid,   1'b0);
      checkOutput("t3_rsp_valid",   bus.rsp_valid,   2'b10);
      checkOutput("t3_rsp_error",   bus.rsp_error,   1'b1);
      checkOutput("t3_rsp_timeout", bus.rsp_timeout, 1'b0);
      checkOutput("t3_rsp_rdata",   bus.rsp_rdata,   32'h0);
      step();
      checkOutput("t3_rsp_end",     bus.rsp_valid,   2'b00);
      checkOutput("t3_mem_valid2",  bus.mem_valid,   1'b0);
      checkOutput("t3_idle",        bus.busy,        1'b0);

      $display("[TB] timeout");
      bus.mem_rdata = 32'hBADBAD00;
      applyStimulus(2'b01, 15'h020, 15'h0, 32'h0, 32'h0, 2'b00);
      #1;
      checkOutput("t4_ready", bus.req_ready, 2'b01);
      step();
      applyStimulus(2'b00, 15'h0, 15'h0, 32'h0, 32'h0, 2'b00);
      hi = 0;
      while (bus.mem_valid === 1'b1 && hi < 70) begin
         hi++;
         step();
      end
      checkOutput("t4_valid_cycles", 64'(hi),          64'd64);
      checkOutput("t4_rsp_valid",    bus.rsp_valid,   2'b01);
      checkOutput("t4_rsp_error",    bus.rsp_error,   1'b1);
      checkOutput("t4_rsp_timeout",  bus.rsp_timeout, 1'b1);
      checkOutput("t4_rsp_rdata",    bus.rsp_rdata,   32'h0);
      step();
      checkOutput("t4_idle", bus.busy, 1'b0);

      applyStimulus(2'b01, 15'h020, 15'h0, 32'h0, 32'h0, 2'b00);
      #1;
      checkOutput("t4b_ready", bus.req_ready, 2'b01);
      step();
      applyStimulus(2'b00, 15'h0, 15'h0, 32'h0, 32'h0, 2'b00);
      repeat (63) step();
      checkOutput("t4b_last_cycle_valid", bus.mem_valid, 1'b1);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hCAFEF00D;
      step();
      bus.mem_ready = 1'b0;
      checkOutput("t4b_rsp_valid",   bus.rsp_valid,   2'b01);
      checkOutput("t4b_rsp_error",   bus.rsp_error,   1'b0);
      checkOutput("t4b_rsp_timeout", bus.rsp_timeout, 1'b0);
      checkOutput("t4b_rsp_rdata",   bus.rsp_rdata,   32'hCAFEF00D);
      step();

      $display("[TB] memory error on write");
      applyStimulus(2'b10, 15'h0, 15'h030, 32'h0, 32'hA5A5A5A5, 2'b10);
      #1;
      checkOutput("t5_ready", bus.req_ready, 2'b10);
      step();
      applyStimulus(2'b00, 15'h0, 15'h0, 32'h0, 32'h0, 2'b00);
      checkOutput("t5_mem_wr_rd", bus.mem_wr_rd, 1'b1);
      checkOutput("t5_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
      checkOutput("t5_mem_addr",  bus.mem_addr,  15'h030);
      bus.mem_ready = 1'b1;
      bus.mem_error = 1'b1;
      bus.mem_rdata = 32'h11111111;
      step();
      bus.mem_ready = 1'b0;
      bus.mem_error = 1'b0;
      checkOutput("t5_rsp_valid",   bus.rsp_valid,   2'b10);
      checkOutput("t5_rsp_error",   bus.rsp_error,   1'b1);
      checkOutput("t5_rsp_timeout", bus.rsp_timeout, 1'b0);
      checkOutput("t5_rsp_rdata",   bus.rsp_rdata,   32'h0);
      step();

      $display("[TB] reset during busy");
      applyStimulus(2'b01, 15'h040, 15'h0, 32'h0, 32'h0, 2'b00);
      #1;
      checkOutput("t6_ready", bus.req_ready, 2'b01);
      step();
      applyStimulus(2'b00, 15'h0, 15'h0, 32'h0, 32'h0, 2'b00);
      checkOutput("t6_mem_valid", bus.mem_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_async_mem_valid", bus.mem_valid, 1'b0);
      checkOutput("t6_async_busy",      bus.busy,      1'b0);
      checkOutput("t6_async_rsp_valid", bus.rsp_valid, 2'b00);
      step();
      step();
      rst = 1'b0;
      step();
      checkOutput("t6_no_lost_rsp", bus.rsp_valid, 2'b00);
      checkOutput("t6_idle",        bus.busy,      1'b0);
      applyStimulus(2'b11, 15'h050, 15'h060, 32'h0, 32'h0, 2'b00);
      #1;
      checkOutput("t6_ptr_reset_grant", bus.req_ready, 2'b01);
      step();
      applyStimulus(2'b00, 15'h0, 15'h0, 32'h0, 32'h0, 2'b00);
      checkOutput("t6_mem_addr", bus.mem_addr, 15'h050);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h600DF00D;
      step();
      bus.mem_ready = 1'b0;
      checkOutput("t6_rsp_valid", bus.rsp_valid, 2'b01);
      checkOutput("t6_rsp_rdata", bus.rsp_rdata, 32'h600DF00D);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
